q65_bus_receiver: RTL and testbench
===================================

Q65_BUS_RECEIVER -- requirements
Module: q65_bus_receiver

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the width of the sampled bus and buffered data.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The module SHALL have port bus_in, input, WIDTH, the shared internal bus value sampled by this block.
REQ-005 The module SHALL have port load, input, 1, a capture strobe: sample bus_in this cycle.
REQ-006 The module SHALL have port out_data, output, WIDTH, the head-of-buffer data.
REQ-007 The module SHALL have port out_valid, output, 1, asserted when the buffer holds at least one entry.
REQ-008 The module SHALL have port out_ready, input, 1, the consumer's accept signal.
REQ-009 The module SHALL have port full, output, 1, asserted when both entries are occupied.
REQ-010 The module SHALL have port overflow, output, 1, a sticky flag marking that a capture was dropped.
REQ-011 The module SHALL have port clear_ovf, input, 1, which clears overflow synchronously.

Function
REQ-012 The module SHALL be a 2-entry FIFO with state EMPTY (count 0), ONE (count 1) or TWO (count 2); full = (state==TWO) and out_valid = (state!=EMPTY).
REQ-013 The module SHALL define pop = out_valid && out_ready, and pop SHALL remove the head entry at the clock edge.
REQ-014 The module SHALL define accept = load && (state!=TWO || pop), and accept SHALL write bus_in, as sampled at that edge, to the tail.
REQ-015 The module SHALL make captured data visible on out_data with out_valid high in the cycle after the capture edge, giving 1-cycle latency; there is no combinational path from bus_in to out_data.
REQ-016 The module SHALL drive out_data from registers: the head entry when non-empty, and all zeros when EMPTY.
REQ-017 The module SHALL use the following state transitions:
- EMPTY: accept -> ONE, otherwise stay.
- ONE: accept and no pop -> TWO; pop and no accept -> EMPTY; both or neither -> ONE.
- TWO: pop and no accept -> ONE; pop and accept -> TWO; otherwise stay.
REQ-018 The module SHALL handle simultaneous accept and pop in ONE so that the old head leaves, the new entry becomes head, and the next out_data equals the newly captured value.
REQ-019 The module SHALL handle simultaneous accept and pop in TWO so that the second entry becomes head and the captured value becomes second, preserving order.
REQ-020 The module SHALL preserve FIFO order at all times; no entry is duplicated, reordered or lost except by the drop rule in REQ-021.
REQ-021 The module SHALL, on load in TWO without pop, discard the bus_in sample, leave the contents unchanged, and set overflow at that edge.
REQ-022 The module SHALL keep overflow set until a clock edge with clear_ovf=1; if a drop and clear_ovf coincide, overflow SHALL remain 1.
REQ-023 The module SHALL ignore out_ready while EMPTY; no underflow is possible and the state does not change.
REQ-024 The module SHALL use storage indices that wrap modulo 2; the wrap SHALL not be visible at the ports.

Reset
REQ-025 The module SHALL, while rst_n=0 and independent of clk, force state=EMPTY, out_data=0, out_valid=0, full=0 and overflow=0, and clear both storage entries to 0.
REQ-026 The module SHALL discard all buffered data when reset asserts mid-operation; the first edge after rst_n rises behaves as EMPTY.
REQ-027 The module SHALL ignore load, out_ready and clear_ovf while rst_n=0.

Verification
REQ-028 The bench SHALL cover single capture: bus_in=8'hA5 with load for 1 cycle and out_ready=0 -> next cycle out_valid=1, out_data=A5, full=0; out_ready=1 for 1 cycle -> EMPTY, out_data=00.
REQ-029 The bench SHALL cover fill and overflow: load 11, 22, 33 on consecutive cycles with out_ready=0 -> full=1 after the second load, 33 dropped, overflow=1; popping yields 11 then 22 then EMPTY.
REQ-030 The bench SHALL cover simultaneous load and pop in TWO: holding {11,22}, load 44 with out_ready=1 -> buffer {22,44}, full stays 1, overflow stays 0.
REQ-031 The bench SHALL cover streaming: load every cycle with out_ready=1 on values 01..10 -> out_data shows 01..10 in order one cycle late, state never TWO, overflow=0.
REQ-032 The bench SHALL cover overflow clear race: overflow=1 and full, with load (no pop) and clear_ovf in the same cycle -> overflow=1; clear_ovf alone next cycle -> overflow=0.
REQ-033 The bench SHALL cover reset mid-operation: buffer {11,22} with overflow=1, pulse rst_n=0 between edges -> all outputs 0 immediately; after release, load 5A -> out_data=5A next cycle.

Source files
------------

// File: rtl/q65_bus_receiver.sv
// Two-entry capture FIFO that samples a shared bus on a load strobe and
// hands entries to a ready/valid consumer, flagging dropped captures.
module q65_bus_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             load,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic             overflow,
    input  logic             clear_ovf
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic             overflow_q, overflow_d;
    logic             pop, accept, drop;

    assign out_valid = (state_q != EMPTY);
    assign full      = (state_q == TWO);
    assign overflow  = overflow_q;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    assign pop    = out_valid && out_ready;
    assign accept = load && (!full || pop);
    assign drop   = load && full && !pop;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !pop)      state_d = TWO;
                else if (pop && !accept) state_d = EMPTY;
            end
            TWO:     if (pop && !accept) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        // A drop in the same cycle as a clear wins, so no loss goes unreported.
        if (drop)           overflow_d = 1'b1;
        else if (clear_ovf) overflow_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the storage entries are reset too, so out_data is all zeros out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            overflow_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept) begin
                // In TWO with a pop, the tail slot is the head slot being vacated.
                mem_q[wr_ptr_q] <= bus_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_q65_bus_receiver.sv
// Scoreboard bench for q65_bus_receiver: accepted captures are queued at
// stimulus time and a monitor compares every popped head against the queue.
module tb_q65_bus_receiver;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] bus_in;
    logic             load;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             full;
    logic             overflow;
    logic             clear_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [WIDTH-1:0] sb_q [$];

    q65_bus_receiver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .load      (load),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [WIDTH-1:0] val, input bit expect_accept);
        bus_in = val;
        load   = 1'b1;
        if (expect_accept) sb_q.push_back(val);
    endtask

    // Monitor: a pop happens at the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("pop_with_empty_scoreboard", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("popped_data", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; bus_in = '0; load = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        #12;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_full", full, 0);
        check("reset_ovf", overflow, 0);
        rst_n = 1'b1;
        cycle();

        // Single capture and pop
        capture(8'hA5, 1); cycle();
        load = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'hA5);
        check("single_full", full, 0);
        out_ready = 1'b1; cycle();
        out_ready = 1'b0;
        check("single_empty_valid", out_valid, 0);
        check("single_empty_data", out_data, 0);

        // Fill and overflow
        capture(8'h11, 1); cycle();
        capture(8'h22, 1); cycle();
        check("fill_full", full, 1);
        capture(8'h33, 0); cycle();
        load = 1'b0;
        check("fill_ovf", overflow, 1);
        check("fill_head", out_data, 8'h11);
        out_ready = 1'b1; cycle();
        check("fill_after_pop1", out_data, 8'h22);
        cycle();
        out_ready = 1'b0;
        check("fill_drained", out_valid, 0);
        clear_ovf = 1'b1; cycle();
        clear_ovf = 1'b0;
        check("fill_ovf_cleared", overflow, 0);

        // Simultaneous load and pop while full
        capture(8'h11, 1); cycle();
        capture(8'h22, 1); cycle();
        capture(8'h44, 1); out_ready = 1'b1; cycle();
        load = 1'b0; out_ready = 1'b0;
        check("two_lp_full", full, 1);
        check("two_lp_ovf", overflow, 0);
        check("two_lp_head", out_data, 8'h22);
        out_ready = 1'b1; cycle();
        check("two_lp_second", out_data, 8'h44);
        cycle();
        out_ready = 1'b0;
        check("two_lp_drained", out_valid, 0);

        // Streaming: one capture and one pop per cycle
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            capture(8'(i), 1); cycle();
            check("stream_data", out_data, i);
            check("stream_not_full", full, 0);
        end
        load = 1'b0; cycle();
        out_ready = 1'b0;
        check("stream_drained", out_valid, 0);
        check("stream_ovf", overflow, 0);

        // Overflow clear racing a drop
        capture(8'h11, 1); cycle();
        capture(8'h22, 1); cycle();
        capture(8'h33, 0); cycle();
        check("race_ovf_set", overflow, 1);
        capture(8'h44, 0); clear_ovf = 1'b1; cycle();
        load = 1'b0;
        check("race_ovf_held", overflow, 1);
        cycle();
        clear_ovf = 1'b0;
        check("race_ovf_cleared", overflow, 0);
        check("race_head", out_data, 8'h11);

        // Reset mid-operation with {11,22} buffered and overflow set
        capture(8'h55, 0); cycle();
        load = 1'b0;
        check("midrst_ovf_pre", overflow, 1);
        #1 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_full", full, 0);
        check("midrst_ovf", overflow, 0);
        #1 rst_n = 1'b1;
        cycle();
        capture(8'h5A, 1); cycle();
        load = 1'b0;
        check("postrst_data", out_data, 8'h5A);
        check("postrst_full", full, 0);
        out_ready = 1'b1; cycle();
        out_ready = 1'b0;
        check("postrst_drained", out_valid, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
